uart_cmd_engine: RTL

- Parametrised UART command decoder between the UART RX/TX byte streams and a register file.
- Decodes a command byte, then either:
  - collects a multi-byte write payload, or
  - issues a read and streams the multi-byte result back over TX with a ready/valid handshake.
- Adds inter-byte and read-response timeouts, and error pulses for timeouts and dropped bytes.

---
 rtl/uart_cmd_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_engine.sv
// UART command decoder: command byte -> multi-byte register write or read streamed back over TX.
// Optional macro UART_CMD_WR_ACK_EN: send a single 0xA5 acknowledge byte after every write.
module uart_cmd_engine #(
  parameter int ADDR_W      = 3,
  parameter int DATA_BYTES  = 1,
  parameter int FIFO_ADDR   = 5,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_data_valid,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_data_valid,
  input  logic                    i_tx_ready,
  output logic [ADDR_W-1:0]       o_addr,
  output logic                    o_rd_req,
  input  logic [8*DATA_BYTES-1:0] i_rd_data,
  input  logic                    i_rd_valid,
  output logic                    o_wr_req,
  output logic [8*DATA_BYTES-1:0] o_wr_data,
  output logic                    o_fifo_fetch,
  output logic                    o_busy,
  output logic                    o_err_timeout,
  output logic                    o_err_drop
);

  localparam int DW   = 8 * DATA_BYTES;
  localparam int CW   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TLIM = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DATA_BYTES - 1);
  localparam logic [TW-1:0]     TIM_LAST = TW'(TLIM);
  localparam logic [ADDR_W-1:0] FIFO_A   = ADDR_W'(FIFO_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_ISSUE,
    RD_REQ,
    RD_WAIT,
    TX
`ifdef UART_CMD_WR_ACK_EN
    , ACK
`endif
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [DW-1:0]     r_shift, w_shift_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DW-1:0]     w_wr_data_nxt;
  logic [7:0]        w_tx_data_nxt;
  logic              w_rd_req_nxt, w_wr_req_nxt, w_fifo_nxt;
  logic              w_err_to_nxt, w_err_drop_nxt, w_tx_valid_nxt;
  logic              w_unused_rx;

  // Command bits above the address field are don't-care.
  assign w_unused_rx = ^i_rx_data;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_timer_nxt    = r_timer;
    w_shift_nxt    = r_shift;
    w_addr_nxt     = o_addr;
    w_wr_data_nxt  = o_wr_data;
    w_tx_data_nxt  = o_tx_data;
    w_rd_req_nxt   = 1'b0;
    w_wr_req_nxt   = 1'b0;
    w_fifo_nxt     = 1'b0;
    w_err_to_nxt   = 1'b0;
    w_err_drop_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_data_valid) begin
          w_addr_nxt  = i_rx_data[ADDR_W:1];
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
          if (i_rx_data[0]) begin
            w_state_nxt = WR_COLLECT;
          end else begin
            w_state_nxt  = RD_REQ;
            w_rd_req_nxt = 1'b1;
            w_fifo_nxt   = (i_rx_data[ADDR_W:1] == FIFO_A);
          end
        end
      end
      WR_COLLECT: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (i_rx_data_valid) begin
          w_wr_data_nxt[8*r_cnt +: 8] = i_rx_data;
          w_timer_nxt = '0;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt  = WR_ISSUE;
            w_wr_req_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (r_timer == TIM_LAST) begin
            w_err_to_nxt = 1'b1;
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_timer_nxt  = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
      end
      WR_ISSUE: begin
        w_err_drop_nxt = i_rx_data_valid;
`ifdef UART_CMD_WR_ACK_EN
        w_state_nxt   = ACK;
        w_tx_data_nxt = 8'hA5;
`else
        w_state_nxt   = IDLE;
`endif
      end
      RD_REQ, RD_WAIT: begin
        w_err_drop_nxt = i_rx_data_valid;
        if (i_rd_valid) begin
          w_shift_nxt   = i_rd_data;
          w_tx_data_nxt = i_rd_data[7:0];
          w_cnt_nxt     = '0;
          w_timer_nxt   = '0;
          w_state_nxt   = TX;
        end else if (r_state == RD_REQ) begin
          w_state_nxt = RD_WAIT;
          w_timer_nxt = '0;
        end else if (TIMEOUT_CYC != 0) begin
          if (r_timer == TIM_LAST) begin
            w_err_to_nxt = 1'b1;
            w_state_nxt  = IDLE;
            w_timer_nxt  = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
      end
      TX: begin
        w_err_drop_nxt = i_rx_data_valid;
        if (i_tx_ready) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt     = r_cnt + CW'(1);
            w_shift_nxt   = r_shift >> 8;
            w_tx_data_nxt = w_shift_nxt[7:0];
          end
        end
      end
`ifdef UART_CMD_WR_ACK_EN
      ACK: begin
        w_err_drop_nxt = i_rx_data_valid;
        if (i_tx_ready) w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
    w_tx_valid_nxt = (w_state_nxt == TX);
`ifdef UART_CMD_WR_ACK_EN
    w_tx_valid_nxt = w_tx_valid_nxt || (w_state_nxt == ACK);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_timer         <= '0;
      r_shift         <= '0;
      o_addr          <= '0;
      o_wr_data       <= '0;
      o_tx_data       <= '0;
      o_tx_data_valid <= 1'b0;
      o_rd_req        <= 1'b0;
      o_wr_req        <= 1'b0;
      o_fifo_fetch    <= 1'b0;
      o_busy          <= 1'b0;
      o_err_timeout   <= 1'b0;
      o_err_drop      <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_timer         <= w_timer_nxt;
      r_shift         <= w_shift_nxt;
      o_addr          <= w_addr_nxt;
      o_wr_data       <= w_wr_data_nxt;
      o_tx_data       <= w_tx_data_nxt;
      o_tx_data_valid <= w_tx_valid_nxt;
      o_rd_req        <= w_rd_req_nxt;
      o_wr_req        <= w_wr_req_nxt;
      o_fifo_fetch    <= w_fifo_nxt;
      o_busy          <= (w_state_nxt != IDLE);
      o_err_timeout   <= w_err_to_nxt;
      o_err_drop      <= w_err_drop_nxt;
    end
  end

endmodule
